// File: rtl/ibwt_pkg.sv
// Shared types and constants for the inverse BWT decoder.
package ibwt_pkg;

  localparam int unsigned IDX_W = 8;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    BUILD_LF,
    WALK,
    DONE
  } state_e;

endpackage

// File: rtl/ibwt_rank_unit.sv
// Combinational LF-mapping for one row: lf = less(L[r]) + occ(L[r], r).
module ibwt_rank_unit
  import ibwt_pkg::*;
#(
  parameter int unsigned STRING_LEN = 8,
  parameter int unsigned SEL_W      = $clog2(STRING_LEN)
) (
  input  logic [7:0]       l [STRING_LEN],
  input  logic [SEL_W-1:0] r,
  output logic [IDX_W-1:0] lf
);

  byte_t            lr;
  logic [IDX_W-1:0] less;
  logic [IDX_W-1:0] occ;

  always_comb begin
    lr   = l[r];
    less = '0;
    occ  = '0;
    for (int j = 0; j < int'(STRING_LEN); j++) begin
      if (l[j] < lr) less = less + IDX_W'(1);
      // Earlier equal bytes only, so ties keep their original order.
      if ((j < int'(r)) && (l[j] == lr)) occ = occ + IDX_W'(1);
    end
    lf = less + occ;
  end

endmodule

// File: rtl/ibwt_decoder.sv
// Inverse Burrows-Wheeler transform: builds the LF table, then walks it backwards.
// Define IBWT_CHECK_EN to flag BWTs whose LF permutation is not a single cycle.
module ibwt_decoder
  import ibwt_pkg::*;
#(
  parameter int unsigned STRING_LEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       bwt_string [STRING_LEN],
  input  logic [IDX_W-1:0] primary_index,
  input  logic             start,
  output logic [7:0]       output_string [STRING_LEN],
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int unsigned SEL_W = $clog2(STRING_LEN);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(STRING_LEN - 1);

  state_e           state_q, state_d;
  byte_t            l_q   [STRING_LEN];
  logic [IDX_W-1:0] lf_q  [STRING_LEN];
  byte_t            buf_q [STRING_LEN];
  byte_t            out_q [STRING_LEN];
  logic [IDX_W-1:0] p_q;
  logic [SEL_W-1:0] r_q, t_q, j_q;
  logic             busy_q, done_q, error_q, err_q;

  logic [IDX_W-1:0] lf_row;
  logic [IDX_W-1:0] j_next;
  logic             p_bad;
  logic             cyc_bad;

  ibwt_rank_unit #(
    .STRING_LEN(STRING_LEN),
    .SEL_W     (SEL_W)
  ) u_rank (
    .l (l_q),
    .r (r_q),
    .lf(lf_row)
  );

  assign p_bad  = p_q >= IDX_W'(STRING_LEN);
  assign j_next = lf_q[j_q];

`ifdef IBWT_CHECK_EN
  // Returning to p early, or not at all, means the LF map has more than one cycle.
  assign cyc_bad = (t_q != '0) ? (j_next == p_q) : (j_next != p_q);
`else
  logic unused_j;
  assign unused_j = ^j_next;
  assign cyc_bad  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = BUILD_LF;
      BUILD_LF: begin
        if (p_bad) state_d = DONE;
        else if (r_q == LAST) state_d = WALK;
      end
      WALK:     if (t_q == '0) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      r_q     <= '0;
      t_q     <= '0;
      j_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(STRING_LEN); i++) begin
        l_q[i]   <= '0;
        lf_q[i]  <= '0;
        buf_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            l_q     <= bwt_string;
            p_q     <= primary_index;
            r_q     <= '0;
            err_q   <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        BUILD_LF: begin
          if (p_bad) begin
            err_q <= 1'b1;
            for (int i = 0; i < int'(STRING_LEN); i++) buf_q[i] <= '0;
          end else begin
            lf_q[r_q] <= lf_row;
            if (r_q == LAST) begin
              t_q <= LAST;
              j_q <= p_q[SEL_W-1:0];
            end else begin
              r_q <= r_q + SEL_W'(1);
            end
          end
        end
        WALK: begin
          buf_q[t_q] <= l_q[j_q];
          j_q        <= j_next[SEL_W-1:0];
          t_q        <= t_q - SEL_W'(1);
          if (cyc_bad) err_q <= 1'b1;
        end
        DONE: begin
          out_q   <= buf_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          error_q <= err_q;
        end
        default: ;
      endcase
    end
  end

  assign output_string = out_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: doc/ibwt_decoder.md
Name: ibwt_decoder

Overview:
- Inverse Burrows-Wheeler transform. Rebuilds the original STRING_LEN-byte string from a BWT last column and a primary index.
- The primary index is the row whose suffix index is 0.
- It is the receive-side counterpart of the suffix-sort BWT encoder and uses the same unpacked byte-array string format.
- Input contract: the original string ends in a unique, strictly smallest terminator byte, so that suffix order equals rotation order.

Parameters:
- STRING_LEN, 8, number of bytes per string (2..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- bwt_string  input  [7:0] x STRING_LEN (unpacked)  BWT last column L; index 0 is row 0.
- primary_index  input  8  row holding suffix 0.
- start  input  1  sampled only in IDLE; captures bwt_string and primary_index.
- output_string  output  [7:0] x STRING_LEN (unpacked)  reconstructed string; index 0 is the first character.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when output_string is updated.
- error  output  1  valid with done; holds until the next accepted start.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - output_string all 0x00; busy=0; done=0; error=0.
  - All internal registers cleared.
  - Reset mid-operation aborts immediately; no done is produced.
- IDLE:
  - On start=1, latch L and p=primary_index into internal registers, clear error, go to BUILD_LF with row counter r=0.
  - If p>=STRING_LEN, go to DONE with error=1; the internal output buffer is zeroed.
- BUILD_LF (STRING_LEN cycles, one row per cycle):
  - less[r] = count of j in 0..N-1 with L[j]<L[r].
  - occ[r] = count of j<r with L[j]==L[r].
  - lf[r] = less[r]+occ[r], 8-bit; the result is always <N for any input.
  - Exit to WALK after r=N-1, with t=N-1 and j=p.
- WALK (STRING_LEN cycles):
  - buf[t]=L[j]; j<=lf[j]; t decrements.
  - Exit to DONE after t=0.
- DONE (1 cycle):
  - output_string<=buf; done<=1 on the next edge.
  - busy falls together with done rising.
  - Return to IDLE.
- Latency:
  - The start-sampling edge is E0. done is observed high after edge E0+2N+1 (N=8 gives 17).
  - On the error path it is observed high after edge E0+2.
- start while busy is ignored.
- start asserted during the done-pulse cycle is accepted, because the FSM is already in IDLE.
- output_string holds its value between operations.
- Ties, equal bytes and byte 0x00 need no special casing; rank by occ gives stable ordering.

Optional Feature:
- Macro: IBWT_CHECK_EN.
- Defined: WALK tracks the LF cycle. error=1 at done if j equals p before the final step, or if j!=p after the last lf step (the LF permutation is not a single N-cycle, so the BWT is invalid). output_string is still loaded with buf.
- Undefined: no cycle check. error reflects only primary_index>=STRING_LEN.

Decomposition:
- Package ibwt_pkg:
  - state enum {IDLE, BUILD_LF, WALK, DONE}, 2 bits.
  - localparam IDX_W=8.
  - byte_t typedef.
- Sub-module ibwt_rank_unit, purely combinational:
  - Inputs: L array and row index r.
  - Output: lf value, computed as N comparators for less plus a masked equality count for occ.
- Top level holds the FSM, counters, lf/buf storage and outputs.

Test Plan:
- L=42 43 43 42 41 41 41 00, p=7, start pulse -> busy=1 for 17 cycles; done pulse; output_string=43 41 42 41 43 41 42 00 ("CABACAB\0"); error=0.
- Same L with p=9 -> done after edge E0+2; error=1; output_string all 00.
- L all 0x41, p=0 -> with IBWT_CHECK_EN: error=1; without it: error=0 and output all 41.
- Start the first vector, pulse start again at cycle 5 with different data -> second start ignored; output matches the first vector; exactly one done pulse.
- Assert rst at cycle 6 of an operation -> done, busy and output immediately 0; next start with the first vector gives the correct result after 17 cycles.
- Back-to-back: assert start in the done cycle with L=00 41 41 41 41 41 41 41... → choose a valid encoder output of "AAAAAAA\0" (L=41 41 41 41 41 41 41 00, p=7) -> second done 17 cycles later; output 41x7,00.
